fastram_arbiter: RTL and testbench

//  Sequences the on-board SRAM mapped by the autoconfig logic and shares it between
//  two requesters: 68K bus cycles (ramce hit) and the Pi-side host port.

---
 rtl/fastram_arbiter_pkg.sv | 25 ++
 rtl/fastram_arbiter_wait_timer.sv | 28 ++
 rtl/fastram_arbiter.sv | 141 ++++++++++++++
 tb/tb_fastram_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fastram_arbiter_pkg.sv
// Shared types for the fast-RAM arbiter: FSM state encoding, grant identity
// and the wait-count width.
package fastram_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CPU_ACC  = 3'd1,
    S_CPU_HOLD = 3'd2,
    S_PI_ACC   = 3'd3,
    S_PI_HOLD  = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_PI  = 1'b1
  } grant_t;

  localparam int unsigned WAIT_W = 2;

  // Clamp a wait-cycle parameter into the 2-bit counter range.
  function automatic logic [WAIT_W-1:0] wait_cfg(input int unsigned w);
    return (w > 3) ? 2'd3 : WAIT_W'(w);
  endfunction

endpackage

// File: rtl/fastram_arbiter_wait_timer.sv
// 2-bit saturating wait counter shared by the CPU and Pi access phases;
// done flags that the programmed number of wait cycles has elapsed.
module fastram_arbiter_wait_timer
  import fastram_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              _RST,
  input  logic              load,
  input  logic              en,
  input  logic [WAIT_W-1:0] target,
  output logic              done
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != 2'd3)) begin
      cnt <= cnt + 2'd1;
    end
  end

  assign done = (cnt == target);

endmodule

// File: rtl/fastram_arbiter.sv
// Fast-RAM arbiter: shares the SRAM between 68K bus cycles and the Pi host port,
// generating registered SRAM strobes, mux selects, DTACK and the Pi handshake.
//
// state      | meaning
// S_IDLE     | SRAM idle, arbitrating between cpu_req and pi_req
// S_CPU_ACC  | 68K access strobes active, counting WAIT_CPU
// S_CPU_HOLD | DTACK asserted, waiting for _AS to rise
// S_PI_ACC   | Pi access strobes active, counting WAIT_PI
// S_PI_HOLD  | pi_ack asserted, waiting for pi_req to fall
module fastram_arbiter
  import fastram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CPU = 1,
  parameter int unsigned WAIT_PI  = 1
) (
  input  logic       CLK,
  input  logic       _RST,
  input  logic       _AS,
  input  logic       _UDS,
  input  logic       _LDS,
  input  logic       RW,
  input  logic       ramce,
  input  logic       pi_req,
  input  logic       pi_rw,
  input  logic [1:0] pi_be,
  output logic       pi_ack,
  output logic       DTACK,
  output logic       _RAMCE,
  output logic       _RAMOE,
  output logic       _RAMWE,
  output logic       _RAMUB,
  output logic       _RAMLB,
  output logic       addr_sel,
  output logic       cpu_oe
);

  state_t      st, st_nxt;
  grant_t      last_grant;
  logic        cpu_req;
  logic        grant, grant_pi;
  logic        acc_rw, acc_rw_nxt;
  logic [1:0]  lane, lane_nxt;
  logic        tmr_load, tmr_en, tmr_done;
  logic [WAIT_W-1:0] tmr_target;
  logic        nxt_idle, nxt_acc, nxt_cpu;

  assign cpu_req = ramce & ~_AS & (~_UDS | ~_LDS);

  // Direction and byte lanes are captured at grant and held for the whole access.
  always_comb begin
    st_nxt     = st;
    grant      = 1'b0;
    grant_pi   = 1'b0;
    acc_rw_nxt = acc_rw;
    lane_nxt   = lane;
    case (st)
      S_IDLE: begin
        if (cpu_req && (!pi_req || (last_grant == GRANT_PI))) begin
          st_nxt     = S_CPU_ACC;
          grant      = 1'b1;
          acc_rw_nxt = RW;
          lane_nxt   = {~_UDS, ~_LDS};
        end else if (pi_req) begin
          st_nxt     = S_PI_ACC;
          grant      = 1'b1;
          grant_pi   = 1'b1;
          acc_rw_nxt = pi_rw;
          lane_nxt   = pi_be;
        end
      end
      S_CPU_ACC: begin
        if (_AS)           st_nxt = S_IDLE;
        else if (tmr_done) st_nxt = S_CPU_HOLD;
      end
      S_CPU_HOLD: begin
        if (_AS) st_nxt = S_IDLE;
      end
      S_PI_ACC: begin
        if (!pi_req)       st_nxt = S_IDLE;
        else if (tmr_done) st_nxt = S_PI_HOLD;
      end
      S_PI_HOLD: begin
        if (!pi_req) st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  assign tmr_load   = (st == S_IDLE);
  assign tmr_en     = (st == S_CPU_ACC) || (st == S_PI_ACC);
  assign tmr_target = (st == S_PI_ACC) ? wait_cfg(WAIT_PI) : wait_cfg(WAIT_CPU);

  fastram_arbiter_wait_timer u_wait_timer (
    .CLK    (CLK),
    ._RST   (_RST),
    .load   (tmr_load),
    .en     (tmr_en),
    .target (tmr_target),
    .done   (tmr_done)
  );

  assign nxt_idle = (st_nxt == S_IDLE);
  assign nxt_acc  = (st_nxt == S_CPU_ACC) || (st_nxt == S_PI_ACC);
  assign nxt_cpu  = (st_nxt == S_CPU_ACC) || (st_nxt == S_CPU_HOLD);

  // Strobes are decoded from the next state so the pins change only on CLK edges.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      st         <= S_IDLE;
      last_grant <= GRANT_PI;
      acc_rw     <= 1'b1;
      lane       <= 2'b00;
      addr_sel   <= 1'b0;
      _RAMCE     <= 1'b1;
      _RAMOE     <= 1'b1;
      _RAMWE     <= 1'b1;
      _RAMUB     <= 1'b1;
      _RAMLB     <= 1'b1;
      cpu_oe     <= 1'b0;
      DTACK      <= 1'b0;
      pi_ack     <= 1'b0;
    end else begin
      st     <= st_nxt;
      acc_rw <= acc_rw_nxt;
      lane   <= lane_nxt;
      if (grant) begin
        last_grant <= grant_pi ? GRANT_PI : GRANT_CPU;
        addr_sel   <= grant_pi;
      end
      _RAMCE <= nxt_idle;
      _RAMUB <= nxt_idle | ~lane_nxt[1];
      _RAMLB <= nxt_idle | ~lane_nxt[0];
      _RAMOE <= nxt_idle | ~acc_rw_nxt;
      _RAMWE <= ~(nxt_acc & ~acc_rw_nxt);
      cpu_oe <= nxt_cpu & acc_rw_nxt;
      DTACK  <= (st_nxt == S_CPU_HOLD);
      pi_ack <= (st_nxt == S_PI_HOLD);
    end
  end

endmodule

// File: tb/tb_fastram_arbiter.sv
// Bench for fastram_arbiter: directed scenarios with literal expectations, then
// randomized CPU/Pi traffic checked every cycle against a transaction-level model.
module tb_fastram_arbiter;

  localparam int WAIT_CPU = 1;
  localparam int WAIT_PI  = 1;

  logic clk = 1'b0;
  logic rst_n, as_n, uds_n, lds_n, rw, ramce, pi_req, pi_rw;
  logic [1:0] pi_be;
  logic pi_ack, dtack, ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n, addr_sel, cpu_oe;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_en = 1'b0;

  fastram_arbiter #(.WAIT_CPU(WAIT_CPU), .WAIT_PI(WAIT_PI)) dut (
    .CLK(clk), ._RST(rst_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .RW(rw),
    .ramce(ramce), .pi_req(pi_req), .pi_rw(pi_rw), .pi_be(pi_be),
    .pi_ack(pi_ack), .DTACK(dtack), ._RAMCE(ram_ce_n), ._RAMOE(ram_oe_n),
    ._RAMWE(ram_we_n), ._RAMUB(ram_ub_n), ._RAMLB(ram_lb_n),
    .addr_sel(addr_sel), .cpu_oe(cpu_oe)
  );

  always #5 clk = ~clk;

  // {_RAMCE,_RAMOE,_RAMWE,_RAMUB,_RAMLB,addr_sel,cpu_oe,DTACK,pi_ack}
  function automatic logic [8:0] outs();
    return {ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n, addr_sel, cpu_oe, dtack, pi_ack};
  endfunction

  // Transaction model: who owns the RAM and how many edges since the grant.
  int   m_owner;  // 0 none, 1 cpu, 2 pi
  int   m_age;
  bit   m_last_pi, m_sel, m_rw;
  logic [1:0] m_lanes;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_age = 0; m_last_pi = 1'b1; m_sel = 1'b0; m_rw = 1'b1; m_lanes = 2'b00;
    end else begin
      bit creq;
      creq = ramce && !as_n && (!uds_n || !lds_n);
      if (m_owner == 0) begin
        if (creq && (!pi_req || m_last_pi)) begin
          m_owner = 1; m_age = 1; m_rw = rw; m_lanes = {!uds_n, !lds_n}; m_sel = 1'b0; m_last_pi = 1'b0;
        end else if (pi_req) begin
          m_owner = 2; m_age = 1; m_rw = pi_rw; m_lanes = pi_be; m_sel = 1'b1; m_last_pi = 1'b1;
        end
      end else if (m_owner == 1) begin
        if (as_n) m_owner = 0; else m_age++;
      end else begin
        if (!pi_req) m_owner = 0; else m_age++;
      end
    end
  end

  function automatic logic [8:0] model_out();
    bit hold;
    if (m_owner == 0) return {5'b11111, m_sel, 3'b000};
    hold = m_age > (((m_owner == 1) ? WAIT_CPU : WAIT_PI) + 1);
    return {1'b0, !m_rw, !(!m_rw && !hold), !m_lanes[1], !m_lanes[0], m_sel,
            (m_owner == 1) && m_rw, (m_owner == 1) && hold, (m_owner == 2) && hold};
  endfunction

  always @(negedge clk) begin
    if (m_en && rst_n) begin
      n_cmp++;
      if (outs() !== model_out()) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL model t=%0t got %b want %b", $time, outs(), model_out());
      end
    end
  end

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_off();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
  endtask

  bit cpu_busy = 1'b0, pi_busy = 1'b0;
  int cpu_age = 0, pi_age = 0;

  initial begin
    rst_n = 1'b0; cpu_off(); rw = 1'b1; ramce = 1'b0;
    pi_req = 1'b0; pi_rw = 1'b1; pi_be = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; m_en = 1'b1;
    tick();
    chk("reset_idle", outs(), 9'b111110000);

    // CPU read, upper byte only
    ramce = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b1; rw = 1'b1;
    tick(); chk("rd_acc1", outs(), 9'b001010100);
    tick(); chk("rd_acc2", outs(), 9'b001010100);
    tick(); chk("rd_hold", outs(), 9'b001010110);
    tick(); chk("rd_hold2", outs(), 9'b001010110);
    cpu_off();
    tick(); chk("rd_release", outs(), 9'b111110000);

    // CPU word write
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
    tick(); chk("wr_acc1", outs(), 9'b010000000);
    tick(); chk("wr_acc2", outs(), 9'b010000000);
    tick(); chk("wr_hold", outs(), 9'b011000010);
    cpu_off();
    tick(); chk("wr_release", outs(), 9'b111110000);

    // Pi write, lower lane only
    pi_req = 1'b1; pi_rw = 1'b0; pi_be = 2'b01;
    tick(); chk("pi_acc1", outs(), 9'b010101000);
    tick(); chk("pi_acc2", outs(), 9'b010101000);
    tick(); chk("pi_hold", outs(), 9'b011101001);
    tick(); chk("pi_hold2", outs(), 9'b011101001);
    pi_req = 1'b0;
    tick(); chk("pi_release", outs(), 9'b111111000);

    // CPU abort during access
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1;
    tick(); chk("abort_acc", outs(), 9'b001000100);
    cpu_off();
    tick(); chk("abort_idle", outs(), 9'b111110000);
    tick(); chk("abort_no_dtack", outs(), 9'b111110000);

    // No base-address hit: never granted
    ramce = 1'b0; as_n = 1'b0; uds_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("no_ramce", outs(), 9'b111110000);
    end
    cpu_off(); ramce = 1'b1;
    tick();

    // Async reset in the middle of a CPU access
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
    tick(); chk("pre_rst_acc", outs(), 9'b010000000);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", outs(), 9'b111110000);
    cpu_off(); rw = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Tie after reset: CPU first, then Pi wins the next tie
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1;
    pi_req = 1'b1; pi_rw = 1'b1; pi_be = 2'b11;
    tick(); chk("tie1_cpu", outs(), 9'b001000100);
    pi_req = 1'b0;
    tick();
    tick(); chk("tie1_hold", outs(), 9'b001000110);
    cpu_off();
    tick(); chk("tie1_done", outs(), 9'b111110000);
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; pi_req = 1'b1;
    tick(); chk("tie2_pi", outs(), 9'b001001000);
    tick();
    tick(); chk("cpu_waits", outs(), 9'b001001001);
    pi_req = 1'b0;
    tick(); chk("pi_done_idle", outs(), 9'b111111000);
    tick(); chk("cpu_after_pi", outs(), 9'b001000100);
    cpu_off();
    tick();

    // Randomized traffic from both requesters
    for (int c = 0; c < 3000; c++) begin
      if (!cpu_busy) begin
        if ($urandom_range(0, 3) == 0) begin
          logic [1:0] ds;
          ds = 2'($urandom_range(0, 3));
          as_n = 1'b0; uds_n = ds[1]; lds_n = ds[0];
          rw = 1'($urandom_range(0, 1));
          ramce = ($urandom_range(0, 9) != 0);
          cpu_busy = 1'b1; cpu_age = 0;
        end
      end else begin
        cpu_age++;
        if (dtack || cpu_age > 20 || $urandom_range(0, 31) == 0) begin
          cpu_off(); cpu_busy = 1'b0;
        end
      end
      if (!pi_busy) begin
        if ($urandom_range(0, 3) == 0) begin
          pi_req = 1'b1;
          pi_rw = 1'($urandom_range(0, 1));
          pi_be = 2'($urandom_range(0, 3));
          pi_busy = 1'b1; pi_age = 0;
        end
      end else begin
        pi_age++;
        if (pi_ack || pi_age > 20 || $urandom_range(0, 31) == 0) begin
          pi_req = 1'b0; pi_busy = 1'b0;
        end
      end
      tick();
    end

    cpu_off(); pi_req = 1'b0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
